// File: rtl/dual_port_main_memory.sv
// Word-addressed main memory: one write port, two independent read ports with a
// fixed-latency {valid, data} pipeline. Define MEM_BOUNDS_CHECK_EN for out-of-range detection.
module dual_port_main_memory #(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_req_0,
    input  logic [31:0] read_address_0,
    input  logic        read_req_1,
    input  logic [31:0] read_address_1,
    input  logic        write_enable,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data_0,
    output logic        read_valid_0,
    output logic [31:0] read_data_1,
    output logic        read_valid_1,
    output logic        addr_error
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [1:0]    rd_req;
    logic [31:0]   rd_addr [2];
    logic [1:0]    rd_oor;
    logic [31:0]   rd_data [2];
    logic [1:0]    rd_valid;
    logic [AW-1:0] wr_index;
    logic          wr_oor;

    assign rd_req     = {read_req_1, read_req_0};
    assign rd_addr[0] = read_address_0;
    assign rd_addr[1] = read_address_1;
    assign wr_index   = write_address[AW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    logic addr_error_reg;

    assign wr_oor = |write_address[31:AW];

    // Sticky: any accepted out-of-range access latches the flag until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_error_reg <= 1'b0;
        end else if ((write_enable && wr_oor) || |(rd_req & rd_oor)) begin
            addr_error_reg <= 1'b1;
        end
    end

    assign addr_error = addr_error_reg;
`else
    logic unused_addr_bits;

    assign wr_oor           = 1'b0;
    assign addr_error       = 1'b0;
    assign unused_addr_bits = ^{write_address[31:AW], read_address_0[31:AW],
                                read_address_1[31:AW], rd_oor};
`endif

    // Writes in the reset cycle are dropped; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && write_enable && !wr_oor) begin
            mem[wr_index] <= write_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [AW-1:0]           index;
            logic [READ_LATENCY-1:0] valid_reg;
            logic [31:0]             data_reg [READ_LATENCY];

            assign index = rd_addr[gi][AW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
            assign rd_oor[gi] = |rd_addr[gi][31:AW];
`else
            assign rd_oor[gi] = 1'b0;
`endif

            // Array is sampled in stage 0 (read-first vs. a same-edge write);
            // later stages only shift, so in-flight data is immune to new writes.
            // Data registers load only with a valid, so outputs hold between reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= '0;
                    for (int s = 0; s < READ_LATENCY; s++) begin
                        data_reg[s] <= '0;
                    end
                end else begin
                    valid_reg[0] <= rd_req[gi];
                    if (rd_req[gi]) begin
                        data_reg[0] <= rd_oor[gi] ? 32'h0000_0000 : mem[index];
                    end
                    for (int s = 1; s < READ_LATENCY; s++) begin
                        valid_reg[s] <= valid_reg[s-1];
                        if (valid_reg[s-1]) begin
                            data_reg[s] <= data_reg[s-1];
                        end
                    end
                end
            end

            assign rd_data[gi]  = data_reg[READ_LATENCY-1];
            assign rd_valid[gi] = valid_reg[READ_LATENCY-1];
        end
    endgenerate

    assign read_data_0  = rd_data[0];
    assign read_valid_0 = rd_valid[0];
    assign read_data_1  = rd_data[1];
    assign read_valid_1 = rd_valid[1];

endmodule

// File: tb/tb_dual_port_main_memory.sv
// Directed bench for dual_port_main_memory (DEPTH=16, READ_LATENCY=3); expectations
// track MEM_BOUNDS_CHECK_EN when it is defined for the whole build.
module tb_dual_port_main_memory;

    localparam int DEPTH = 16;
    localparam int RL    = 3;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic        EXP_ERR  = 1'b1;
    localparam logic [31:0] EXP_MEM4 = 32'h4444_4444;
    localparam logic [31:0] EXP_RD20 = 32'h0000_0000;
`else
    localparam logic        EXP_ERR  = 1'b0;
    localparam logic [31:0] EXP_MEM4 = 32'h0000_ABCD;
    localparam logic [31:0] EXP_RD20 = 32'h0000_ABCD;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        read_req_0, read_req_1, write_enable;
    logic [31:0] read_address_0, read_address_1, write_address, write_data;
    logic [31:0] read_data_0, read_data_1;
    logic        read_valid_0, read_valid_1, addr_error;

    always #5 clk = ~clk;

    dual_port_main_memory #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk            (clk),
        .rst            (rst),
        .read_req_0     (read_req_0),
        .read_address_0 (read_address_0),
        .read_req_1     (read_req_1),
        .read_address_1 (read_address_1),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_data     (write_data),
        .read_data_0    (read_data_0),
        .read_valid_0   (read_valid_0),
        .read_data_1    (read_data_1),
        .read_valid_1   (read_valid_1),
        .addr_error     (addr_error)
    );

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [12];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        read_req_0     = 1'b0;
        read_req_1     = 1'b0;
        write_enable   = 1'b0;
        read_address_0 = '0;
        read_address_1 = '0;
        write_address  = '0;
        write_data     = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            we    waddr  wdata          r0    a0     r1    a1     e0             e1
        vecs[0]  = '{1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 32'd0, 32'h0,         1'b0, 32'd0, 1'b1, 32'd5, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'd7, 32'h1111_1111, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,         32'h0};
        vecs[3]  = '{1'b1, 32'd7, 32'h2222_2222, 1'b1, 32'd7, 1'b0, 32'd0, 32'h1111_1111, 32'h0};
        vecs[4]  = '{1'b0, 32'd0, 32'h0,         1'b1, 32'd7, 1'b1, 32'd5, 32'h2222_2222, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'd0, 32'h0000_00A0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 32'd1, 32'h0000_00A1, 1'b1, 32'd0, 1'b1, 32'd7, 32'h0000_00A0, 32'h2222_2222};
        vecs[7]  = '{1'b1, 32'd2, 32'h0000_00A2, 1'b1, 32'd1, 1'b0, 32'd0, 32'h0000_00A1, 32'h0};
        vecs[8]  = '{1'b1, 32'd3, 32'h0000_00A3, 1'b0, 32'd0, 1'b1, 32'd2, 32'h0,         32'h0000_00A2};
        vecs[9]  = '{1'b0, 32'd0, 32'h0,         1'b1, 32'd3, 1'b1, 32'd3, 32'h0000_00A3, 32'h0000_00A3};
        vecs[10] = '{1'b1, 32'd4, 32'h4444_4444, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 32'd0, 32'h0,         1'b1, 32'd4, 1'b0, 32'd0, 32'h4444_4444, 32'h0};

        // Reset with a pending fetch request: nothing may come out.
        clear_inputs();
        rst        = 1'b1;
        read_req_0 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_valid0", {31'b0, read_valid_0}, 32'd0);
            check("rst_valid1", {31'b0, read_valid_1}, 32'd0);
            check("rst_data0", read_data_0, 32'd0);
            check("rst_data1", read_data_1, 32'd0);
            check("rst_err", {31'b0, addr_error}, 32'd0);
        end
        rst        = 1'b0;
        read_req_0 = 1'b0;
        for (int c = 0; c < RL; c++) begin
            step();
            check("post_rst_valid0", {31'b0, read_valid_0}, 32'd0);
            check("post_rst_valid1", {31'b0, read_valid_1}, 32'd0);
            check("post_rst_err", {31'b0, addr_error}, 32'd0);
        end

        // Table: one transaction at a time, data lands RL edges later for one cycle.
        for (int i = 0; i < 12; i++) begin
            write_enable   = vecs[i].we;
            write_address  = vecs[i].waddr;
            write_data     = vecs[i].wdata;
            read_req_0     = vecs[i].r0;
            read_address_0 = vecs[i].a0;
            read_req_1     = vecs[i].r1;
            read_address_1 = vecs[i].a1;
            step();
            clear_inputs();
            repeat (RL - 1) step();
            $display("vec %0d: v0=%b d0=%h v1=%b d1=%h", i, read_valid_0, read_data_0, read_valid_1, read_data_1);
            check("vec_valid0", {31'b0, read_valid_0}, {31'b0, vecs[i].r0});
            check("vec_valid1", {31'b0, read_valid_1}, {31'b0, vecs[i].r1});
            if (vecs[i].r0) check("vec_data0", read_data_0, vecs[i].e0);
            if (vecs[i].r1) check("vec_data1", read_data_1, vecs[i].e1);
            step();
            check("vec_drop0", {31'b0, read_valid_0}, 32'd0);
            check("vec_drop1", {31'b0, read_valid_1}, 32'd0);
            if (vecs[i].r0) check("vec_hold0", read_data_0, vecs[i].e0);
            if (vecs[i].r1) check("vec_hold1", read_data_1, vecs[i].e1);
        end

        // Back-to-back port 0 reads of 0..3 with a concurrent port 1 read of 3.
        for (int k = 0; k < 4 + RL; k++) begin
            int   idx;
            logic exp_v0;
            logic exp_v1;
            read_req_0     = (k < 4);
            read_address_0 = k;
            read_req_1     = (k == 3);
            read_address_1 = 32'd3;
            step();
            idx    = k - (RL - 1);
            exp_v0 = (idx >= 0) && (idx < 4);
            exp_v1 = (k == 3 + RL - 1);
            $display("pipe cycle %0d: v0=%b d0=%h v1=%b d1=%h", k, read_valid_0, read_data_0, read_valid_1, read_data_1);
            check("pipe_valid0", {31'b0, read_valid_0}, {31'b0, exp_v0});
            check("pipe_valid1", {31'b0, read_valid_1}, {31'b0, exp_v1});
            if (exp_v0) check("pipe_data0", read_data_0, 32'h0000_00A0 + idx);
            if (exp_v1) check("pipe_data1", read_data_1, 32'h0000_00A3);
        end
        clear_inputs();

        // Out-of-range write and read at address 20 (aliases index 4).
        write_enable  = 1'b1;
        write_address = 32'd20;
        write_data    = 32'h0000_ABCD;
        step();
        clear_inputs();
        check("oor_write_err", {31'b0, addr_error}, {31'b0, EXP_ERR});
        read_req_0     = 1'b1;
        read_address_0 = 32'd4;
        step();
        clear_inputs();
        repeat (RL - 1) step();
        $display("bounds mem4: v0=%b d0=%h err=%b", read_valid_0, read_data_0, addr_error);
        check("oor_mem4_valid", {31'b0, read_valid_0}, 32'd1);
        check("oor_mem4_data", read_data_0, EXP_MEM4);
        read_req_1     = 1'b1;
        read_address_1 = 32'd20;
        step();
        clear_inputs();
        repeat (RL - 1) step();
        $display("bounds rd20: v1=%b d1=%h err=%b", read_valid_1, read_data_1, addr_error);
        check("oor_rd20_valid", {31'b0, read_valid_1}, 32'd1);
        check("oor_rd20_data", read_data_1, EXP_RD20);
        check("oor_err_sticky", {31'b0, addr_error}, {31'b0, EXP_ERR});

        // Reset lands one edge after a load request: the request must vanish.
        read_req_1     = 1'b1;
        read_address_1 = 32'd5;
        step();
        read_req_1 = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid1", {31'b0, read_valid_1}, 32'd0);
        check("mid_rst_data1", read_data_1, 32'd0);
        check("mid_rst_err", {31'b0, addr_error}, 32'd0);
        for (int c = 0; c < RL; c++) begin
            step();
            check("mid_rst_no_valid1", {31'b0, read_valid_1}, 32'd0);
        end

        // Array survives reset.
        read_req_0     = 1'b1;
        read_address_0 = 32'd7;
        read_req_1     = 1'b1;
        read_address_1 = 32'd5;
        step();
        clear_inputs();
        repeat (RL - 1) step();
        $display("after reset: v0=%b d0=%h v1=%b d1=%h", read_valid_0, read_data_0, read_valid_1, read_data_1);
        check("keep_valid0", {31'b0, read_valid_0}, 32'd1);
        check("keep_data0", read_data_0, 32'h2222_2222);
        check("keep_valid1", {31'b0, read_valid_1}, 32'd1);
        check("keep_data1", read_data_1, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
